mem_bus_arbiter: RTL and testbench

//  Shares one downstream memory_bus slave between NUM_REQ masters (CPU data port, blitter/DMA, debug).

---
 rtl/mem_arb_pkg.sv | 41 ++++
 rtl/mem_bus_arbiter_if.sv | 51 +++++
 rtl/mem_bus_arbiter_rr.sv | 40 ++++
 rtl/mem_bus_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types for the memory-bus arbiter. It holds the access
//                width encoding, the arbiter FSM states, the per-port request
//                slot record and a round-robin pointer helper.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    // Slot fields are sized for the widest supported bus. The arbiter
    // parameters ADDR_W/DATA_W must not exceed these widths.
    localparam int SLOT_ADDR_W = 32;
    localparam int SLOT_DATA_W = 32;

    typedef enum logic [1:0] {
        WIDTH_BYTE  = 2'd0,
        WIDTH_WORD  = 2'd1,
        WIDTH_DWORD = 2'd2
    } mem_width_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                   is_write;
        logic [SLOT_ADDR_W-1:0] addr;
        mem_width_t             width;
        logic [SLOT_DATA_W-1:0] wdata;
    } req_slot_t;

    // Port index that follows cur, wrapping at n.
    function automatic int unsigned next_port(input int unsigned cur, input int unsigned n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter_if
//  Description : Bundle of the requester-side and downstream memory-bus
//                signals of the arbiter.
//                slave  : arbiter view (takes requests, drives memory bus)
//                master : surrounding-system view (requesters + memory slave)
//  Ports       : req_rd_in/req_wr_in/req_addr_in/req_width_in/req_wdata_in,
//                req_busy_out/req_rdata_out, mem_rd_out/mem_wr_out/
//                mem_addr_out/mem_width_out/mem_wdata_out, mem_busy_in,
//                mem_rdata_in, err_out
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_bus_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_rd_in;
    logic [NUM_REQ-1:0]        req_wr_in;
    logic [NUM_REQ*ADDR_W-1:0] req_addr_in;
    logic [NUM_REQ*2-1:0]      req_width_in;
    logic [NUM_REQ*DATA_W-1:0] req_wdata_in;
    logic [NUM_REQ-1:0]        req_busy_out;
    logic [NUM_REQ*DATA_W-1:0] req_rdata_out;
    logic                      mem_rd_out;
    logic                      mem_wr_out;
    logic [ADDR_W-1:0]         mem_addr_out;
    logic [1:0]                mem_width_out;
    logic [DATA_W-1:0]         mem_wdata_out;
    logic                      mem_busy_in;
    logic [DATA_W-1:0]         mem_rdata_in;
    logic                      err_out;

    modport slave (
        input  req_rd_in, req_wr_in, req_addr_in, req_width_in, req_wdata_in,
        input  mem_busy_in, mem_rdata_in,
        output req_busy_out, req_rdata_out,
        output mem_rd_out, mem_wr_out, mem_addr_out, mem_width_out, mem_wdata_out,
        output err_out
    );

    modport master (
        output req_rd_in, req_wr_in, req_addr_in, req_width_in, req_wdata_in,
        output mem_busy_in, mem_rdata_in,
        input  req_busy_out, req_rdata_out,
        input  mem_rd_out, mem_wr_out, mem_addr_out, mem_width_out, mem_wdata_out,
        input  err_out
    );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Selects the first asserted
//                request at or after ptr, wrapping at N.
//  Ports       : req (in, N), ptr (in) ; grant (out, one-hot), index (out),
//                any (out)
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] index,
    output logic             any
);
    int pos;

    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!any && req[pos]) begin
                any        = 1'b1;
                grant[pos] = 1'b1;
                index      = IDX_W'(pos);
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter
//  Description : Shares one downstream memory slave between NUM_REQ pulse-
//                dispatch masters. Each pulse is latched into a per-port slot,
//                slots are served round-robin, and each is replayed downstream
//                as a single transaction. Read data is held per port.
//  Ports       : clk_in (clock), rst_in (sync, active-low), bus (slave modport)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    mem_bus_arbiter_if.slave  bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t                state_q, state_d;
    logic [IDX_W-1:0]          owner_q, owner_d;
    logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]        pending_q;
    req_slot_t                 slot_q [NUM_REQ];
    logic                      err_q;
    logic [NUM_REQ*DATA_W-1:0] rdata_q;

    logic                      mem_rd_q, mem_rd_d;
    logic                      mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0]         mem_addr_q, mem_addr_d;
    logic [1:0]                mem_width_q, mem_width_d;
    logic [DATA_W-1:0]         mem_wdata_q, mem_wdata_d;

    logic [NUM_REQ-1:0]        grant_oh;
    logic [IDX_W-1:0]          grant_idx;
    logic                      grant_any;
    logic                      take_grant;
    logic                      complete;

    logic [NUM_REQ-1:0]        dispatch;
    logic [NUM_REQ-1:0]        owner_active;
    logic [NUM_REQ-1:0]        port_busy;
    logic [NUM_REQ-1:0]        capture;
    logic                      violation;

    rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req   (pending_q),
        .ptr   (rr_ptr_q),
        .grant (grant_oh),
        .index (grant_idx),
        .any   (grant_any)
    );

    // ------------------------------------------------------------------
    // Per-port request qualification
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_port
        assign owner_active[i] = (state_q != ARB_IDLE) && (owner_q == IDX_W'(i));
    end

    assign dispatch  = bus.req_rd_in | bus.req_wr_in;
    assign port_busy = pending_q | owner_active;
    // A port already holding a slot or the bus cannot queue a second request.
    assign capture   = dispatch & ~port_busy;
    assign violation = (|(bus.req_rd_in & bus.req_wr_in)) | (|(dispatch & port_busy));

    assign bus.req_busy_out  = dispatch | port_busy;
    assign bus.req_rdata_out = rdata_q;
    assign bus.err_out       = err_q;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            pending_q <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            pending_q <= (pending_q & ~(take_grant ? grant_oh : '0)) | capture;
            err_q     <= err_q | violation;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (capture[i]) begin
                    // Write wins when both strobes arrive together.
                    slot_q[i] <= '{
                        is_write : bus.req_wr_in[i],
                        addr     : SLOT_ADDR_W'(bus.req_addr_in[i*ADDR_W +: ADDR_W]),
                        width    : mem_width_t'(bus.req_width_in[i*2 +: 2]),
                        wdata    : SLOT_DATA_W'(bus.req_wdata_in[i*DATA_W +: DATA_W])
                    };
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q     <= ARB_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_width_q <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_width_q <= mem_width_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_width_d = mem_width_q;
        mem_wdata_d = mem_wdata_q;
        take_grant  = 1'b0;
        complete    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (grant_any) begin
                    take_grant  = 1'b1;
                    owner_d     = grant_idx;
                    mem_rd_d    = !slot_q[grant_idx].is_write;
                    mem_wr_d    = slot_q[grant_idx].is_write;
                    mem_addr_d  = ADDR_W'(slot_q[grant_idx].addr);
                    mem_width_d = slot_q[grant_idx].width;
                    mem_wdata_d = DATA_W'(slot_q[grant_idx].wdata);
                    state_d     = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (!bus.mem_busy_in) begin
                    complete = 1'b1;
                    // The port just served moves to the back of the queue.
                    rr_ptr_d = IDX_W'(next_port(int'(owner_q), NUM_REQ));
                    state_d  = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Read data is held per port until a later read from that port completes.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            rdata_q <= '0;
        end else if (complete && !slot_q[owner_q].is_write) begin
            rdata_q[int'(owner_q)*DATA_W +: DATA_W] <= bus.mem_rdata_in;
        end
    end

    assign bus.mem_rd_out    = mem_rd_q;
    assign bus.mem_wr_out    = mem_wr_q;
    assign bus.mem_addr_out  = mem_addr_q;
    assign bus.mem_width_out = mem_width_q;
    assign bus.mem_wdata_out = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bus_arbiter
//  Description : Directed scoreboard bench for mem_bus_arbiter. Expected
//                downstream transactions are queued at stimulus time and
//                popped by a monitor whenever the arbiter pulses the bus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_bus_arbiter;
    import mem_arb_pkg::*;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_bus_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [1:0]  width;
        logic [31:0] wdata;
    } tx_t;

    tx_t exp_q[$];
    int  checks = 0;
    int  passes = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // ---------------- downstream slave model ----------------
    int          slv_cnt;
    logic [31:0] slv_addr;

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        case (a)
            32'h100: return 32'hDEAD_BEEF;
            32'h300: return 32'h0000_0011;
            32'h400: return 32'h0000_0022;
            default: return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    // Busy for three cycles after each pulse, then data with busy low.
    always @(posedge clk) begin
        if (!rst_n) begin
            bus.mem_busy_in  <= 1'b0;
            bus.mem_rdata_in <= '0;
            slv_cnt          <= 0;
        end else if (bus.mem_rd_out || bus.mem_wr_out) begin
            bus.mem_busy_in  <= 1'b1;
            bus.mem_rdata_in <= '0;
            slv_cnt          <= 3;
            slv_addr         <= bus.mem_addr_out;
        end else if (slv_cnt > 1) begin
            slv_cnt <= slv_cnt - 1;
        end else if (slv_cnt == 1) begin
            slv_cnt          <= 0;
            bus.mem_busy_in  <= 1'b0;
            bus.mem_rdata_in <= slave_data(slv_addr);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        tx_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (bus.mem_rd_out || bus.mem_wr_out)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_pulse: got rd=%0b wr=%0b addr=0x%0h, expected no transaction",
                             bus.mem_rd_out, bus.mem_wr_out, bus.mem_addr_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_op", {30'd0, bus.mem_rd_out, bus.mem_wr_out}, e.wr ? 32'd1 : 32'd2);
                    chk("pulse_addr", bus.mem_addr_out, e.addr);
                    chk("pulse_width", {30'd0, bus.mem_width_out}, {30'd0, e.width});
                    if (e.wr) chk("pulse_wdata", bus.mem_wdata_out, e.wdata);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_reqs();
        bus.req_rd_in    = '0;
        bus.req_wr_in    = '0;
        bus.req_addr_in  = '0;
        bus.req_width_in = '0;
        bus.req_wdata_in = '0;
    endtask

    task automatic set_req(input int p, input bit wr, input logic [31:0] a,
                           input logic [1:0] w, input logic [31:0] d);
        if (wr) bus.req_wr_in[p] = 1'b1;
        else    bus.req_rd_in[p] = 1'b1;
        bus.req_addr_in[p*AW +: AW] = a;
        bus.req_width_in[p*2 +: 2]  = w;
        bus.req_wdata_in[p*DW +: DW] = d;
    endtask

    task automatic expect_tx(input bit wr, input logic [31:0] a,
                             input logic [1:0] w, input logic [31:0] d);
        tx_t t;
        t.wr = wr; t.addr = a; t.width = w; t.wdata = d;
        exp_q.push_back(t);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_reqs();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_quiet(input string nm);
        int n;
        n = 0;
        while ((bus.req_busy_out != '0 || exp_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            $display("FAIL %s_timeout: got busy=%b queued=%0d, expected idle", nm, bus.req_busy_out, exp_q.size());
        end
    endtask

    function automatic logic [31:0] rdata_of(input int p);
        return bus.req_rdata_out[p*DW +: DW];
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        int          rem [2];
        int          sent[2];
        logic [1:0]  nb;
        int          cyc;

        clear_reqs();
        do_reset();
        @(negedge clk);
        chk("rst_busy",  {30'd0, bus.req_busy_out}, 32'd0);
        chk("rst_pulse", {30'd0, bus.mem_rd_out, bus.mem_wr_out}, 32'd0);
        chk("rst_addr",  bus.mem_addr_out, 32'd0);
        chk("rst_rdata0", rdata_of(0), 32'd0);
        chk("rst_err",   {31'd0, bus.err_out}, 32'd0);

        // 1: single read, latency and held data
        @(posedge clk); #1;
        set_req(0, 1'b0, 32'h100, WIDTH_DWORD, 32'd0);
        expect_tx(1'b0, 32'h100, WIDTH_DWORD, 32'd0);
        @(negedge clk);
        chk("t1_busy_T", {31'd0, bus.req_busy_out[0]}, 32'd1);
        chk("t1_pulse_T", {31'd0, bus.mem_rd_out}, 32'd0);
        @(posedge clk); #1 clear_reqs();
        @(negedge clk);
        chk("t1_pulse_T1", {31'd0, bus.mem_rd_out}, 32'd0);
        @(negedge clk);
        chk("t1_pulse_T2", {31'd0, bus.mem_rd_out}, 32'd1);
        repeat (4) @(negedge clk);
        chk("t1_busy_T6", {31'd0, bus.req_busy_out[0]}, 32'd1);
        @(negedge clk);
        chk("t1_busy_T7", {31'd0, bus.req_busy_out[0]}, 32'd0);
        chk("t1_rdata0", rdata_of(0), 32'hDEAD_BEEF);

        // 2: simultaneous read (port0) and byte write (port1) after reset
        do_reset();
        @(posedge clk); #1;
        set_req(0, 1'b0, 32'h180, WIDTH_WORD, 32'd0);
        set_req(1, 1'b1, 32'h200, WIDTH_BYTE, 32'hAB);
        expect_tx(1'b0, 32'h180, WIDTH_WORD, 32'd0);
        expect_tx(1'b1, 32'h200, WIDTH_BYTE, 32'hAB);
        @(posedge clk); #1 clear_reqs();
        wait_quiet("t2");
        chk("t2_rdata0", rdata_of(0), 32'hA5A5_0180);
        chk("t2_rdata1", rdata_of(1), 32'd0);

        // 3: continuous re-dispatch from both ports, grants alternate
        for (int k = 0; k < 3; k++) begin
            expect_tx(1'b0, 32'h1000 + k*16, WIDTH_DWORD, 32'd0);
            expect_tx(1'b1, 32'h2000 + k*16, WIDTH_DWORD, 32'h5000 + k);
        end
        rem[0] = 3; rem[1] = 3; sent[0] = 0; sent[1] = 0;
        nb = '0;
        cyc = 0;
        while ((rem[0] > 0 || rem[1] > 0) && cyc < 500) begin
            @(posedge clk); #1 clear_reqs();
            for (int p = 0; p < 2; p++) begin
                if (!nb[p] && rem[p] > 0) begin
                    set_req(p, p == 1, (p == 0 ? 32'h1000 : 32'h2000) + sent[p]*16,
                            WIDTH_DWORD, 32'h5000 + sent[p]);
                    sent[p]++;
                    rem[p]--;
                end
            end
            @(negedge clk);
            nb = bus.req_busy_out;
            cyc++;
        end
        if (cyc >= 500) begin
            checks++;
            $display("FAIL t3_dispatch_timeout: got %0d/%0d left, expected 0/0", rem[0], rem[1]);
        end
        @(posedge clk); #1 clear_reqs();
        wait_quiet("t3");
        chk("t3_rdata0", rdata_of(0), 32'hA5A5_1020);

        // 4: second dispatch while pending -> sticky error, served once
        @(negedge clk);
        chk("t4_err_before", {31'd0, bus.err_out}, 32'd0);
        @(posedge clk); #1;
        set_req(1, 1'b1, 32'h600, WIDTH_WORD, 32'h66);
        expect_tx(1'b1, 32'h600, WIDTH_WORD, 32'h66);
        @(posedge clk); #1 clear_reqs();
        set_req(1, 1'b1, 32'h700, WIDTH_WORD, 32'h77);
        @(posedge clk); #1 clear_reqs();
        @(negedge clk);
        chk("t4_err_set", {31'd0, bus.err_out}, 32'd1);
        wait_quiet("t4");
        repeat (5) @(negedge clk);
        chk("t4_err_sticky", {31'd0, bus.err_out}, 32'd1);

        // 5: reset while waiting on the slave
        @(posedge clk); #1;
        set_req(0, 1'b0, 32'h800, WIDTH_DWORD, 32'd0);
        expect_tx(1'b0, 32'h800, WIDTH_DWORD, 32'd0);
        @(posedge clk); #1 clear_reqs();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_busy", {30'd0, bus.req_busy_out}, 32'd0);
        chk("t5_pulse", {30'd0, bus.mem_rd_out, bus.mem_wr_out}, 32'd0);
        chk("t5_rdata0", rdata_of(0), 32'd0);
        chk("t5_err", {31'd0, bus.err_out}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t5_busy_after", {30'd0, bus.req_busy_out}, 32'd0);
        chk("t5_no_replay", exp_q.size(), 32'd0);

        // 6: read-data hold per port
        @(posedge clk); #1;
        set_req(0, 1'b0, 32'h300, WIDTH_DWORD, 32'd0);
        expect_tx(1'b0, 32'h300, WIDTH_DWORD, 32'd0);
        @(posedge clk); #1 clear_reqs();
        wait_quiet("t6a");
        chk("t6_rdata0_first", rdata_of(0), 32'h11);
        @(posedge clk); #1;
        set_req(1, 1'b0, 32'h400, WIDTH_DWORD, 32'd0);
        expect_tx(1'b0, 32'h400, WIDTH_DWORD, 32'd0);
        @(posedge clk); #1 clear_reqs();
        wait_quiet("t6b");
        chk("t6_rdata0_held", rdata_of(0), 32'h11);
        chk("t6_rdata1", rdata_of(1), 32'h22);

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
`default_nettype wire
